// File: rtl/sp_mem_arbiter_pkg.sv
// Shared types and the round-robin pick used by the scratchpad memory-port arbiter.
package sp_mem_arbiter_pkg;

  typedef enum logic [1:0] {ARB_IDLE, ARB_LOAD, ARB_STORE} arb_state_t;
  typedef enum logic {OWN_LOAD, OWN_STORE} arb_owner_t;

  // On a tie the side that was not granted last wins; a lone requester always wins.
  function automatic arb_owner_t rr_pick(input logic ld, input logic st, input arb_owner_t last);
    if (ld && st) return (last == OWN_LOAD) ? OWN_STORE : OWN_LOAD;
    else if (st)  return OWN_STORE;
    else          return OWN_LOAD;
  endfunction

endpackage

// File: rtl/sp_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between the load and dramstore FSMs.
// Optional perf counters (grants per side, wait cycles) under SP_MEM_ARB_PERF_EN.
module sp_mem_arbiter
  import sp_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 1024
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic              ld_hit,
  output logic [DATA_W-1:0] ld_rdata,
  input  logic              st_req,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [DATA_W-1:0] st_wdata,
  output logic              st_hit,
  output logic              mem_ren,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_hit,
  input  logic [DATA_W-1:0] mem_rdata,
`ifdef SP_MEM_ARB_PERF_EN
  output logic [31:0]       ld_grant_cnt,
  output logic [31:0]       st_grant_cnt,
  output logic [31:0]       wait_cnt,
`endif
  output logic              timeout_err
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TCNT_LAST = TW'(TIMEOUT - 1);

  arb_state_t        state_q, state_d;
  arb_owner_t        rr_last_q, rr_last_d;
  logic              mem_ren_q, mem_ren_d;
  logic              mem_wen_q, mem_wen_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [TW-1:0]     tcnt_q, tcnt_d;
  logic              timeout_err_q, timeout_err_d;
  arb_owner_t        pick;
  logic              busy;

  assign pick = rr_pick(ld_req, st_req, rr_last_q);
  assign busy = (state_q != ARB_IDLE);

  always_comb begin
    state_d       = state_q;
    rr_last_d     = rr_last_q;
    mem_ren_d     = 1'b0;
    mem_wen_d     = 1'b0;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    tcnt_d        = tcnt_q;
    timeout_err_d = timeout_err_q;
    case (state_q)
      ARB_IDLE: begin
        if (ld_req || st_req) begin
          rr_last_d = pick;
          tcnt_d    = '0;
          if (pick == OWN_LOAD) begin
            state_d    = ARB_LOAD;
            mem_ren_d  = 1'b1;
            mem_addr_d = ld_addr;
          end else begin
            state_d     = ARB_STORE;
            mem_wen_d   = 1'b1;
            mem_addr_d  = st_addr;
            mem_wdata_d = st_wdata;
          end
        end
      end
      ARB_LOAD, ARB_STORE: begin
        // A hit on the final watchdog cycle still counts as a normal completion.
        if (mem_hit) begin
          state_d = ARB_IDLE;
          tcnt_d  = '0;
        end else if (tcnt_q == TCNT_LAST) begin
          state_d       = ARB_IDLE;
          tcnt_d        = '0;
          timeout_err_d = 1'b1;
        end else begin
          tcnt_d    = tcnt_q + 1'b1;
          mem_ren_d = (state_q == ARB_LOAD);
          mem_wen_d = (state_q == ARB_STORE);
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (nRST) begin
      state_q       <= ARB_IDLE;
      rr_last_q     <= OWN_STORE;
      mem_ren_q     <= 1'b0;
      mem_wen_q     <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      tcnt_q        <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_last_q     <= rr_last_d;
      mem_ren_q     <= mem_ren_d;
      mem_wen_q     <= mem_wen_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      tcnt_q        <= tcnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Completion is forwarded in the hit cycle itself; a reset in that cycle swallows it.
  assign ld_hit      = (state_q == ARB_LOAD)  && mem_hit && !nRST;
  assign st_hit      = (state_q == ARB_STORE) && mem_hit && !nRST;
  assign ld_rdata    = ld_hit ? mem_rdata : '0;
  assign mem_ren     = mem_ren_q;
  assign mem_wen     = mem_wen_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign timeout_err = timeout_err_q;

`ifdef SP_MEM_ARB_PERF_EN
  logic [31:0] ld_grant_cnt_q, ld_grant_cnt_d;
  logic [31:0] st_grant_cnt_q, st_grant_cnt_d;
  logic [31:0] wait_cnt_q, wait_cnt_d;
  logic        ld_grant, st_grant, wait_ev;

  assign ld_grant = !busy && (ld_req || st_req) && (pick == OWN_LOAD);
  assign st_grant = !busy && (ld_req || st_req) && (pick == OWN_STORE);
  assign wait_ev  = busy && !mem_hit;

  always_comb begin
    ld_grant_cnt_d = ld_grant_cnt_q;
    st_grant_cnt_d = st_grant_cnt_q;
    wait_cnt_d     = wait_cnt_q;
    if (ld_grant && (ld_grant_cnt_q != '1)) ld_grant_cnt_d = ld_grant_cnt_q + 32'd1;
    if (st_grant && (st_grant_cnt_q != '1)) st_grant_cnt_d = st_grant_cnt_q + 32'd1;
    if (wait_ev  && (wait_cnt_q     != '1)) wait_cnt_d     = wait_cnt_q + 32'd1;
  end

  always_ff @(posedge CLK) begin
    if (nRST) begin
      ld_grant_cnt_q <= '0;
      st_grant_cnt_q <= '0;
      wait_cnt_q     <= '0;
    end else begin
      ld_grant_cnt_q <= ld_grant_cnt_d;
      st_grant_cnt_q <= st_grant_cnt_d;
      wait_cnt_q     <= wait_cnt_d;
    end
  end

  assign ld_grant_cnt = ld_grant_cnt_q;
  assign st_grant_cnt = st_grant_cnt_q;
  assign wait_cnt     = wait_cnt_q;
`endif

endmodule

// File: tb/tb_sp_mem_arbiter.sv
// Bench for sp_mem_arbiter: directed scenarios plus random traffic against a
// transaction-level reference model (owner, age, last grant, grant log).
module tb_sp_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int TO = 8;

  logic          CLK = 1'b0;
  logic          nRST = 1'b1;
  logic          ld_req = 1'b0, st_req = 1'b0, mem_hit = 1'b0;
  logic [AW-1:0] ld_addr = '0, st_addr = '0;
  logic [DW-1:0] st_wdata = '0, mem_rdata = '0;
  logic          ld_hit, st_hit, mem_ren, mem_wen, timeout_err;
  logic [DW-1:0] ld_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
`ifdef SP_MEM_ARB_PERF_EN
  logic [31:0]   ld_grant_cnt, st_grant_cnt, wait_cnt;
`endif

  always #5 CLK = ~CLK;

  sp_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .CLK(CLK), .nRST(nRST),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_hit(ld_hit), .ld_rdata(ld_rdata),
    .st_req(st_req), .st_addr(st_addr), .st_wdata(st_wdata), .st_hit(st_hit),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_hit(mem_hit), .mem_rdata(mem_rdata),
`ifdef SP_MEM_ARB_PERF_EN
    .ld_grant_cnt(ld_grant_cnt), .st_grant_cnt(st_grant_cnt), .wait_cnt(wait_cnt),
`endif
    .timeout_err(timeout_err)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: owner 0=none 1=load 2=store.
  int            m_own = 0, m_last = 2, m_age = 0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0;
  logic          m_err = 1'b0;
  logic          m_ld_hit = 1'b0, m_st_hit = 1'b0;
  int            grants[$];
  int            m_ldg = 0, m_stg = 0, m_wait = 0;

  task automatic step(input logic rst, input logic lr, input logic [AW-1:0] la,
                      input logic sr, input logic [AW-1:0] sa, input logic [DW-1:0] sw,
                      input logic mh, input logic [DW-1:0] mr);
    logic eld, est;
    @(negedge CLK);
    nRST = rst; ld_req = lr; ld_addr = la; st_req = sr; st_addr = sa; st_wdata = sw;
    mem_hit = mh; mem_rdata = mr;
    #1;
    eld = !rst && (m_own == 1) && mh;
    est = !rst && (m_own == 2) && mh;
    chk("mem_ren", 64'(mem_ren), 64'(m_own == 1));
    chk("mem_wen", 64'(mem_wen), 64'(m_own == 2));
    chk("both_strobes", 64'(mem_ren & mem_wen), 64'd0);
    chk("mem_addr", 64'(mem_addr), 64'(m_addr));
    chk("mem_wdata", mem_wdata, m_wdata);
    chk("ld_hit", 64'(ld_hit), 64'(eld));
    chk("ld_rdata", ld_rdata, eld ? mr : 64'd0);
    chk("st_hit", 64'(st_hit), 64'(est));
    chk("timeout_err", 64'(timeout_err), 64'(m_err));
    if (rst) begin
      m_own = 0; m_last = 2; m_age = 0; m_addr = '0; m_wdata = '0; m_err = 1'b0;
      m_ldg = 0; m_stg = 0; m_wait = 0;
    end else if (m_own == 0) begin
      if (lr || sr) begin
        m_own  = (lr && sr) ? ((m_last == 1) ? 2 : 1) : (lr ? 1 : 2);
        m_last = m_own;
        m_age  = 0;
        grants.push_back(m_own);
        if (m_own == 1) begin m_addr = la; m_ldg++; end
        else begin m_addr = sa; m_wdata = sw; m_stg++; end
      end
    end else begin
      if (!mh) m_wait++;
      if (mh) m_own = 0;
      else if (m_age == TO - 1) begin m_own = 0; m_err = 1'b1; end
      else m_age++;
    end
    m_ld_hit = eld; m_st_hit = est;
  endtask

  task automatic idle(input logic rst);
    step(rst, 1'b0, '0, 1'b0, '0, '0, 1'b0, '0);
  endtask

  initial begin
    logic          lr, sr, mh, rst, seen;
    logic [AW-1:0] la, sa;
    logic [DW-1:0] sw;
    int            n, cyc;

    repeat (2) @(posedge CLK);
    idle(1'b1);
    idle(1'b0);

    // Single load, hit in third strobe cycle.
    step(1'b0, 1'b1, 32'h1000, 1'b0, '0, '0, 1'b0, '0);
    chk("ld_lat_c0_ren", 64'(mem_ren), 64'd0);
    step(1'b0, 1'b1, 32'h1000, 1'b0, '0, '0, 1'b0, '0);
    chk("ld_lat_c1_ren", 64'(mem_ren), 64'd1);
    chk("ld_lat_addr", 64'(mem_addr), 64'h1000);
    step(1'b0, 1'b1, 32'h1000, 1'b0, '0, '0, 1'b0, '0);
    chk("ld_lat_c2_ren", 64'(mem_ren), 64'd1);
    step(1'b0, 1'b1, 32'h1000, 1'b0, '0, '0, 1'b1, 64'hCAFE_F00D_1234_5678);
    chk("ld_lat_c3_ren", 64'(mem_ren), 64'd1);
    chk("ld_lat_hit", 64'(ld_hit), 64'd1);
    chk("ld_lat_rdata", ld_rdata, 64'hCAFE_F00D_1234_5678);
    idle(1'b0);
    chk("ld_lat_c4_ren", 64'(mem_ren), 64'd0);

    // Both requesting continuously: strict alternation from reset.
    idle(1'b1);
    grants.delete();
    cyc = 0;
    while (!(grants.size() >= 6 && m_own == 0) && cyc < 100) begin
      lr = (grants.size() < 6);
      step(1'b0, lr, 32'h100 + 32'(cyc), lr, 32'h200 + 32'(cyc), 64'(cyc),
           (m_own != 0) && (m_age == 1), {$urandom, $urandom});
      cyc++;
    end
    chk("alt_done", 64'(cyc < 100), 64'd1);
    chk("alt_count", 64'(grants.size()), 64'd6);
    for (int i = 0; i < 6 && i < grants.size(); i++)
      chk("alt_order", 64'(grants[i]), (i % 2 == 0) ? 64'd1 : 64'd2);

    // Store address changed mid-transaction is ignored.
    step(1'b0, 1'b0, '0, 1'b1, 32'h20, 64'hDEAD, 1'b0, '0);
    step(1'b0, 1'b0, '0, 1'b1, 32'h40, 64'hBEEF, 1'b0, '0);
    chk("st_addr_hold", 64'(mem_addr), 64'h20);
    step(1'b0, 1'b0, '0, 1'b1, 32'h40, 64'hBEEF, 1'b1, '0);
    chk("st_addr_hit", 64'(mem_addr), 64'h20);
    chk("st_wdata_hit", mem_wdata, 64'hDEAD);
    chk("st_hit_dir", 64'(st_hit), 64'd1);
    idle(1'b0);

    // Watchdog: store with no memory response.
    step(1'b0, 1'b0, '0, 1'b1, 32'h80, 64'h5555, 1'b0, '0);
    n = 0; seen = 1'b0;
    for (int i = 0; i < TO; i++) begin
      step(1'b0, 1'b0, '0, 1'b1, 32'h80, 64'h5555, 1'b0, '0);
      n += int'(mem_wen);
      seen |= st_hit;
    end
    idle(1'b0);
    chk("to_strobe_cycles", 64'(n), 64'(TO));
    chk("to_wen_dropped", 64'(mem_wen), 64'd0);
    chk("to_err", 64'(timeout_err), 64'd1);
    chk("to_no_st_hit", 64'(seen), 64'd0);
    step(1'b0, 1'b1, 32'h300, 1'b0, '0, '0, 1'b0, '0);
    step(1'b0, 1'b1, 32'h300, 1'b0, '0, '0, 1'b1, 64'h77);
    chk("to_next_served", 64'(ld_hit), 64'd1);
    chk("to_err_sticky", 64'(timeout_err), 64'd1);
    idle(1'b0);

    // Reset during LOAD abandons the access and clears the error.
    step(1'b0, 1'b1, 32'h400, 1'b0, '0, '0, 1'b0, '0);
    step(1'b0, 1'b1, 32'h400, 1'b0, '0, '0, 1'b0, '0);
    step(1'b1, 1'b1, 32'h400, 1'b0, '0, '0, 1'b1, 64'h99);
    chk("rst_no_ld_hit", 64'(ld_hit), 64'd0);
    idle(1'b0);
    chk("rst_ren_low", 64'(mem_ren), 64'd0);
    chk("rst_err_clr", 64'(timeout_err), 64'd0);

`ifdef SP_MEM_ARB_PERF_EN
    idle(1'b1);
    grants.delete();
    cyc = 0;
    while (!(grants.size() >= 5 && m_own == 0) && cyc < 100) begin
      lr = (grants.size() < 5);
      step(1'b0, lr, 32'h10, lr, 32'h20, 64'h1, (m_own != 0) && (m_age == 1), '0);
      cyc++;
    end
    chk("perf_ld_grants", 64'(ld_grant_cnt), 64'd3);
    chk("perf_st_grants", 64'(st_grant_cnt), 64'd2);
    chk("perf_wait", 64'(wait_cnt), 64'd5);
`endif

    // Random traffic against the model.
    idle(1'b1);
    lr = 1'b0; sr = 1'b0; la = '0; sa = '0; sw = '0;
    for (int c = 0; c < 3000; c++) begin
      if (lr && m_ld_hit) lr = 1'b0;
      if (sr && m_st_hit) sr = 1'b0;
      if (!lr && ($urandom % 3 == 0)) begin lr = 1'b1; la = $urandom; end
      if (!sr && ($urandom % 3 == 0)) begin sr = 1'b1; sa = $urandom; sw = {$urandom, $urandom}; end
      mh  = ($urandom % 4 == 0);
      rst = ($urandom % 400 == 0);
      step(rst, lr, la, sr, sa, sw, mh, {$urandom, $urandom});
    end
`ifdef SP_MEM_ARB_PERF_EN
    chk("rnd_ld_grants", 64'(ld_grant_cnt), 64'(m_ldg));
    chk("rnd_st_grants", 64'(st_grant_cnt), 64'(m_stg));
    chk("rnd_wait", 64'(wait_cnt), 64'(m_wait));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
